icache_refill: RTL
==================

# icache_refill

Miss handler and refill engine for the direct-mapped instruction cache storage. It watches the fetch lookup result, tracks up to NUM_MSHR outstanding line misses, and issues tagged line loads to the shared memory bus. It writes returning lines into the cache storage write port, using the same cycle that the matching memory tag arrives.

## Interface
Parameters:
- NUM_LINES, 16, cache lines; power of two.
- TAG_BITS, 25, stored tag width; must equal 29 - log2(NUM_LINES).
- DATA_BITS, 64, line width (8-byte lines).
- NUM_MSHR, 4, outstanding miss entries, range 1..8.
- MEM_TAG_BITS, 4, memory transaction tag width; tag 0 means "none".

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- fetch_valid  in  1  fetch lookup active this cycle.
- fetch_addr  in  32  fetch byte address.
- fetch_hit  in  1  cache storage hit for fetch_addr.
- proc2mem_command  out  2  2'b00 none, 2'b01 load.
- proc2mem_addr  out  32  line-aligned load address; low 3 bits are 0.
- mem2proc_response  in  MEM_TAG_BITS  nonzero = request accepted with this tag; 0 = rejected.
- mem2proc_data  in  DATA_BITS  returning line data.
- mem2proc_tag  in  MEM_TAG_BITS  tag of returning data; 0 = no data.
- wr_en  out  1  cache storage write enable.
- wr_idx  out  log2(NUM_LINES)  write line index.
- wr_tag  out  TAG_BITS  write tag.
- wr_data  out  DATA_BITS  write data.
- miss_stall  out  1  fetch must hold; equals fetch_valid & ~fetch_hit.
- mshr_full  out  1  no FREE entry.

## Operation
- Address split: bits [2:0] are the offset. Bits [log2(NUM_LINES)+2:3] are the index. Bits [31:log2(NUM_LINES)+3] are the tag. The line address is addr[31:3].
- Each MSHR entry has a state, a line address, and a mem_tag. States are FREE, WAIT_ISSUE and WAIT_DATA.
- Allocate: when fetch_valid & ~fetch_hit is true, no non-FREE entry holds the same line address, and a FREE entry exists, the lowest-index FREE entry takes the line and moves to WAIT_ISSUE at the next edge.
  - An entry already tracking the line suppresses allocation, including an entry being filled this cycle.
- Issue: the lowest-index WAIT_ISSUE entry drives proc2mem_command=01 and proc2mem_addr={line,3'b0}.
  - If mem2proc_response != 0, that entry moves to WAIT_DATA at the edge and stores mem_tag = response.
  - If mem2proc_response is 0, the entry stays in WAIT_ISSUE and retries the next cycle.
  - Only one request is issued per cycle.
- Fill: when mem2proc_tag != 0 and it equals the mem_tag of a WAIT_DATA entry, the block drives, in the same cycle:
  - wr_en=1;
  - wr_idx and wr_tag taken from the entry;
  - wr_data = mem2proc_data.
  - The entry returns to FREE at the edge.
- Tags that match no entry (other bus clients, or responses from before a reset) are ignored; wr_en=0.
- Allocation reads the registered entry states. An entry freed by a fill in cycle t is not allocatable until cycle t+1.
- Allocation, issue and fill may all occur in one cycle, on different entries.
- miss_stall is purely combinational and is independent of MSHR occupancy.

## Timing
- Reset asserted (reset=0) clears all entries to FREE immediately.
- During reset, every output is forced to 0: proc2mem_command=00, proc2mem_addr=0, wr_en=0, wr_idx=0, wr_tag=0, wr_data=0, miss_stall=0, mshr_full=0.
- Miss detected in cycle t: request is visible in cycle t+1 at the earliest.
- Accepted response in cycle t+1: entry is in WAIT_DATA from t+2.
- Data tag in cycle k: wr_en is high in cycle k; the cache hits from k+1; the entry is FREE from k+1.
- mshr_full is registered-state derived. It is 1 when all NUM_MSHR entries are non-FREE; allocation is blocked while it is 1.
- Reset asserted mid-transaction drops all tracking. Memory data still in flight is ignored after reset because no entry matches.

## Configuration
- ICACHE_PREFETCH_EN defined: on every demand allocation of line L, the block also allocates line L+1 in the same cycle, into the next-lowest FREE entry.
  - Line address arithmetic is 29-bit and wraps 0x1FFFFFFF to 0.
  - The prefetch allocation is skipped if no second FREE entry exists or L+1 is already tracked.
  - The demand entry always has the lower index, so it issues first.
  - Prefetch fills write the cache like demand fills.
- ICACHE_PREFETCH_EN undefined: demand allocation only.

## Test plan
- Single miss:
  - Stimulus: fetch_addr=0x0000_1048 with fetch_hit=0; response=3 in the first request cycle; mem2proc_tag=3 five cycles later.
  - Required: proc2mem_addr=0x1048 issued once; wr_en=1 with wr_idx=9, wr_tag=0x20, wr_data=mem2proc_data; entry FREE afterwards.
- Rejection retry:
  - Stimulus: response=0 for 3 cycles, then 5.
  - Required: the same address is held for 4 cycles; fill on tag 5 succeeds.
- Duplicate suppression:
  - Stimulus: the same missing line is presented for 10 cycles.
  - Required: exactly one load is issued.
- Full table:
  - Stimulus: 4 distinct missing lines, all accepted, no data returned.
  - Required: mshr_full=1; a 5th miss does not allocate; after tag return, mshr_full=0 the next cycle and the 5th line allocates.
- Reset mid-flight:
  - Stimulus: reset=0 while 2 entries are in WAIT_DATA; release; then return their old tags.
  - Required: all outputs 0 during reset; wr_en stays 0 for the stale tags.
- Prefetch (macro defined):
  - Stimulus: a miss on line 0x1FFFFFFF.
  - Required: loads issue to 0xFFFF_FFF8 and then 0x0000_0000.

Source files
------------

// File: rtl/icache_refill.sv
// Miss handler / refill engine for the direct-mapped instruction cache.
// Optional next-line prefetch is enabled by defining ICACHE_PREFETCH_EN.
module icache_refill #(
    parameter int NUM_LINES    = 16,
    parameter int TAG_BITS     = 25,
    parameter int DATA_BITS    = 64,
    parameter int NUM_MSHR     = 4,
    parameter int MEM_TAG_BITS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          fetch_valid,
    input  logic [31:0]                   fetch_addr,
    input  logic                          fetch_hit,
    output logic [1:0]                    proc2mem_command,
    output logic [31:0]                   proc2mem_addr,
    input  logic [MEM_TAG_BITS-1:0]       mem2proc_response,
    input  logic [DATA_BITS-1:0]          mem2proc_data,
    input  logic [MEM_TAG_BITS-1:0]       mem2proc_tag,
    output logic                          wr_en,
    output logic [$clog2(NUM_LINES)-1:0]  wr_idx,
    output logic [TAG_BITS-1:0]           wr_tag,
    output logic [DATA_BITS-1:0]          wr_data,
    output logic                          miss_stall,
    output logic                          mshr_full
);

    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int LINE_BITS = 29;
    localparam int MI        = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    typedef enum logic [1:0] {
        ST_FREE       = 2'd0,
        ST_WAIT_ISSUE = 2'd1,
        ST_WAIT_DATA  = 2'd2
    } mshr_state_t;

    mshr_state_t                 state_reg  [NUM_MSHR];
    mshr_state_t                 state_next [NUM_MSHR];
    logic [LINE_BITS-1:0]        line_reg   [NUM_MSHR];
    logic [LINE_BITS-1:0]        line_next  [NUM_MSHR];
    logic [MEM_TAG_BITS-1:0]     mtag_reg   [NUM_MSHR];
    logic [MEM_TAG_BITS-1:0]     mtag_next  [NUM_MSHR];

    logic [NUM_MSHR-1:0] is_free;
    logic [NUM_MSHR-1:0] is_wait_issue;
    logic [NUM_MSHR-1:0] hit_fetch_line;
    logic [NUM_MSHR-1:0] hit_pf_line;
    logic [NUM_MSHR-1:0] hit_fill;

    logic                 miss;
    logic [LINE_BITS-1:0] fetch_line;
    logic [LINE_BITS-1:0] pf_line;

    logic          alloc_ok, pf_ok, issue_ok, fill_ok;
    logic [MI-1:0] alloc_idx, pf_idx, issue_idx, fill_idx;
    logic          free_found, second_found;

    logic unused_offset;
    assign unused_offset = ^fetch_addr[2:0];

    assign miss       = fetch_valid & ~fetch_hit;
    assign fetch_line = fetch_addr[31:3];
    assign pf_line    = fetch_line + 29'd1;

    // Per-entry match terms; only tracked (non-FREE) entries can match a line.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MSHR; gi++) begin : g_match
            assign is_free[gi]        = (state_reg[gi] == ST_FREE);
            assign is_wait_issue[gi]  = (state_reg[gi] == ST_WAIT_ISSUE);
            assign hit_fetch_line[gi] = !is_free[gi] && (line_reg[gi] == fetch_line);
            assign hit_pf_line[gi]    = !is_free[gi] && (line_reg[gi] == pf_line);
            assign hit_fill[gi]       = (state_reg[gi] == ST_WAIT_DATA) &&
                                        (mem2proc_tag != '0) &&
                                        (mtag_reg[gi] == mem2proc_tag);
        end
    endgenerate

    // Priority pickers: lowest and second-lowest FREE, lowest WAIT_ISSUE, lowest fill match.
    always_comb begin
        free_found   = 1'b0;
        second_found = 1'b0;
        alloc_idx    = '0;
        pf_idx       = '0;
        issue_ok     = 1'b0;
        issue_idx    = '0;
        fill_ok      = 1'b0;
        fill_idx     = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (is_free[i]) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    alloc_idx  = MI'(i);
                end else if (!second_found) begin
                    second_found = 1'b1;
                    pf_idx       = MI'(i);
                end
            end
            if (is_wait_issue[i] && !issue_ok) begin
                issue_ok  = 1'b1;
                issue_idx = MI'(i);
            end
            if (hit_fill[i] && !fill_ok) begin
                fill_ok  = 1'b1;
                fill_idx = MI'(i);
            end
        end
    end

    assign alloc_ok = miss && !(|hit_fetch_line) && free_found;

`ifdef ICACHE_PREFETCH_EN
    assign pf_ok = alloc_ok && second_found && !(|hit_pf_line);
`else
    assign pf_ok = 1'b0;
`endif

    // Next-state for every entry; allocation, issue and fill always target distinct entries.
    always_comb begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            state_next[i] = state_reg[i];
            line_next[i]  = line_reg[i];
            mtag_next[i]  = mtag_reg[i];
            if (issue_ok && (MI'(i) == issue_idx) && (mem2proc_response != '0)) begin
                state_next[i] = ST_WAIT_DATA;
                mtag_next[i]  = mem2proc_response;
            end
            if (fill_ok && (MI'(i) == fill_idx)) begin
                state_next[i] = ST_FREE;
            end
            if (alloc_ok && (MI'(i) == alloc_idx)) begin
                state_next[i] = ST_WAIT_ISSUE;
                line_next[i]  = fetch_line;
            end
            if (pf_ok && (MI'(i) == pf_idx)) begin
                state_next[i] = ST_WAIT_ISSUE;
                line_next[i]  = pf_line;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_MSHR; gi++) begin : g_entry
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_reg[gi] <= ST_FREE;
                    line_reg[gi]  <= '0;
                    mtag_reg[gi]  <= '0;
                end else begin
                    state_reg[gi] <= state_next[gi];
                    line_reg[gi]  <= line_next[gi];
                    mtag_reg[gi]  <= mtag_next[gi];
                end
            end
        end
    endgenerate

    // Every output is held at zero while reset is asserted.
    always_comb begin
        proc2mem_command = 2'b00;
        proc2mem_addr    = '0;
        wr_en            = 1'b0;
        wr_idx           = '0;
        wr_tag           = '0;
        wr_data          = '0;
        miss_stall       = 1'b0;
        mshr_full        = 1'b0;
        if (reset) begin
            miss_stall = miss;
            mshr_full  = !free_found;
            if (issue_ok) begin
                proc2mem_command = 2'b01;
                proc2mem_addr    = {line_reg[issue_idx], 3'b000};
            end
            if (fill_ok) begin
                wr_en   = 1'b1;
                wr_idx  = line_reg[fill_idx][IDX_BITS-1:0];
                wr_tag  = line_reg[fill_idx][IDX_BITS +: TAG_BITS];
                wr_data = mem2proc_data;
            end
        end
    end

endmodule
